fp_pow_int: RTL and testbench
=============================

// Module: fp_pow_int
// PURPOSE
//  Iterative IEEE-754 single-precision integer-power unit: result = X^N, N unsigned.
//  Square-and-multiply, LSB first, on one time-shared `mult` instance.
//  Sits upstream of `mult` and feeds it both operands every cycle.
//  Consumes its result/overflow/underflow; serves the Power calculator datapath.
// PARAMETERS
//  NBITS   8   width of integer exponent N (1..16)
// PORTS
//  CLK        in   1      clock, rising edge
//  RST        in   1      asynchronous, active-low reset
//  start      in   1      request; sampled only in IDLE
//  X          in   32     base operand, IEEE-754 single
//  N          in   NBITS  exponent, unsigned
//  busy       out  1      high while computing (cycle after accepted start until done)
//  done       out  1      one-cycle pulse; result/flags valid from this cycle on
//  result     out  32     X^N, held until next accepted start
//  overflow   out  1      sticky OR of mult overflow over this operation
//  underflow  out  1      sticky OR of mult underflow over this operation
// BEHAVIOUR
//  Reset (RST=0, any time incl. mid-operation): state=IDLE.
//   busy=0, done=0, result=0, overflow=0, underflow=0.
//   Internal acc/base/e cleared; in-flight operation discarded.
//  Registers: acc[31:0], base[31:0], e[NBITS-1:0], state.
//  States IDLE, MULA, SQR, FIN; each state occupies exactly one cycle.
//  IDLE: start=1 -> acc<=FP_ONE (32'h3F800000), base<=X, e<=N.
//   Clear overflow/underflow.
//   Next state FIN if N==0, else MULA.
//  MULA: mult operands (acc, base).
//   If e[0]: acc<=product and OR flags into sticky flags; else acc unchanged.
//   Next: SQR if (e>>1)!=0, else FIN.
//  SQR: mult operands (base, base); base<=product, OR flags, e<=e>>1. Next MULA.
//   Every computed square is consumed later; no wasted square after the MSB.
//  FIN: result<=acc, done=1 for this cycle only, busy=0. Next IDLE.
//  Mux select drives mult operands in IDLE/FIN (acc,acc); product ignored there.
//  Latency: accepted start at edge 0; done high in cycle 2m+2.
//   m = index of N's highest set bit. N==0: done in cycle 1. N==1: cycle 2.
//  start while busy or in FIN: ignored, not queued.
//  N==0: result=FP_ONE for every X, incl. zero/Inf/NaN; flags 0.
//  Special operands (zero, Inf, NaN, sign) are resolved by mult/export_result; no extra handling.
//  Sign falls out naturally: negative X, odd N -> negative result.
//  Flags are not gated by later products; an early overflow stays set.
//  mult.enable output unused.
// STRUCTURE
//  Shared package fp_pkg: FP_ONE, FP_ZERO, state encoding.
//  Sub-module: existing `mult` only, one instance, combinational path from acc/base regs.
//  Controller FSM + operand mux stay inline in fp_pow_int.
// TESTING
//  X=0x40000000 (2.0), N=10 -> result 0x44800000 (1024.0), done in cycle 8, flags 0.
//  X=0x40400000 (3.0), N=0 -> result 0x3F800000, done in cycle 1, busy never high.
//  X=0xBFC00000 (-1.5), N=3 -> result 0xC0580000 (-3.375), done in cycle 4.
//  X=0x71800000 (2^100), N=2 -> overflow=1, underflow=0 at done.
//   X=0x0D800000 (2^-100), N=2 -> underflow=1, result exponent field 0.
//  Back-to-back: start pulsed while busy (N=10 run) ignored.
//   Second start after done recomputes, flags cleared.
//  RST low in cycle 3 of N=10 run -> all outputs 0 immediately (async).
//   After release, new start X=2.0 N=1 -> 0x40000000 in cycle 2.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point constants and the power unit's controller state encoding.
package fp_pkg;

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULA,
        ST_SQR,
        ST_FIN
    } state_t;

endpackage

// File: rtl/mult.sv
// Combinational IEEE-754 single multiplier, round-to-nearest-even.
// Subnormals flush to zero on input and output.
module mult (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] product,
    output logic        overflow,
    output logic        underflow,
    output logic        enable
);

    logic               sign;
    logic               a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic [47:0]        p, norm;
    logic [23:0]        mant;
    logic               rnd, stk;
    logic [24:0]        mant_r;
    logic [22:0]        frac;
    logic signed [10:0] exp_pre, exp_r;

    assign sign   = a[31] ^ b[31];
    assign a_nan  = (&a[30:23]) & (|a[22:0]);
    assign a_inf  = (&a[30:23]) & ~(|a[22:0]);
    assign a_zero = ~(|a[30:23]);
    assign b_nan  = (&b[30:23]) & (|b[22:0]);
    assign b_inf  = (&b[30:23]) & ~(|b[22:0]);
    assign b_zero = ~(|b[30:23]);

    // Significand product lies in [2^46, 2^48); normalise so the leading one sits at bit 47.
    assign p       = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    assign norm    = p[47] ? p : {p[46:0], 1'b0};
    assign exp_pre = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]})
                     - 11'sd127 + $signed({10'd0, p[47]});
    assign mant    = norm[47:24];
    assign rnd     = norm[23];
    assign stk     = |norm[22:0];
    assign mant_r  = {1'b0, mant} + {24'd0, rnd & (stk | mant[0])};
    assign exp_r   = exp_pre + $signed({10'd0, mant_r[24]});
    assign frac    = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    always_comb begin
        product   = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        enable    = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            product = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            product = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            product = {sign, 31'd0};
        end else begin
            enable = 1'b1;
            if (exp_r >= 11'sd255) begin
                product  = {sign, 8'hFF, 23'd0};
                overflow = 1'b1;
            end else if (exp_r <= 11'sd0) begin
                product   = {sign, 31'd0};
                underflow = 1'b1;
            end else begin
                product = {sign, exp_r[7:0], frac};
            end
        end
    end

endmodule

// File: rtl/fp_pow_int.sv
// Iterative X^N (N unsigned) by LSB-first square-and-multiply on one shared multiplier.
module fp_pow_int
    import fp_pkg::*;
#(
    parameter int unsigned NBITS = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [31:0]      X,
    input  logic [NBITS-1:0] N,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result,
    output logic             overflow,
    output logic             underflow
);

    state_t           state;
    logic [31:0]      acc, base;
    logic [NBITS-1:0] e;
    logic [31:0]      op_a, op_b, prod;
    logic             p_ovf, p_unf;
    logic             unused_mult_enable;

    always_comb begin
        op_a = acc;
        op_b = acc;
        case (state)
            ST_MULA: begin op_a = acc;  op_b = base; end
            ST_SQR:  begin op_a = base; op_b = base; end
            default: begin op_a = acc;  op_b = acc;  end
        endcase
    end

    mult u_mult (
        .a         (op_a),
        .b         (op_b),
        .product   (prod),
        .overflow  (p_ovf),
        .underflow (p_unf),
        .enable    (unused_mult_enable)
    );

    // done/result are loaded on the edge entering FIN so they are valid during the FIN cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            acc       <= '0;
            base      <= '0;
            e         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= FP_ZERO;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc       <= FP_ONE;
                        base      <= X;
                        e         <= N;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        if (N == '0) begin
                            state  <= ST_FIN;
                            result <= FP_ONE;
                            done   <= 1'b1;
                        end else begin
                            state <= ST_MULA;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_MULA: begin
                    if (e[0]) begin
                        acc       <= prod;
                        overflow  <= overflow | p_ovf;
                        underflow <= underflow | p_unf;
                    end
                    if ((e >> 1) != '0) begin
                        state <= ST_SQR;
                    end else begin
                        state  <= ST_FIN;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= e[0] ? prod : acc;
                    end
                end
                ST_SQR: begin
                    base      <= prod;
                    overflow  <= overflow | p_ovf;
                    underflow <= underflow | p_unf;
                    e         <= e >> 1;
                    state     <= ST_MULA;
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_pow_int.sv
// Self-checking bench for fp_pow_int: directed spec cases plus randomized runs against a real-arithmetic model.
module tb_fp_pow_int;

    localparam int unsigned NB = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [31:0]   X;
    logic [NB-1:0] N;
    logic          busy, done, overflow, underflow;
    logic [31:0]   result;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    fp_pow_int #(.NBITS(NB)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .X         (X),
        .N         (N),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Single -> double (exact), normal or zero operands only.
    function automatic real sp2r(input logic [31:0] s);
        logic [10:0] e11;
        if (s[30:23] == 8'd0) return 0.0;
        e11 = {3'b000, s[30:23]} + 11'd896;
        return $bitstoreal({s[31], e11, s[22:0], 29'd0});
    endfunction

    // Double -> single with round-to-nearest-even; assumes a normal single result.
    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [22:0] keep;
        logic [28:0] rem;
        logic [7:0]  e8;
        logic [23:0] sum;
        logic        inc;
        d = $realtobits(r);
        if (r == 0.0) return {d[63], 31'd0};
        keep = d[51:29];
        rem  = d[28:0];
        e8   = 8'(d[62:52] - 11'd896);
        inc  = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
        sum  = {1'b0, keep} + {23'd0, inc};
        if (sum[23]) e8 = e8 + 8'd1;
        return {d[63], e8, sum[22:0]};
    endfunction

    // X^N with one rounding per multiplication, consuming exponent bits LSB first.
    function automatic logic [31:0] model_pow(input logic [31:0] x, input int unsigned n);
        logic [31:0] acc = 32'h3F80_0000;
        logic [31:0] b   = x;
        int unsigned k   = n;
        while (k != 0) begin
            if (k % 2 == 1) acc = r2sp(sp2r(acc) * sp2r(b));
            k = k / 2;
            if (k != 0) b = r2sp(sp2r(b) * sp2r(b));
        end
        return acc;
    endfunction

    function automatic int model_lat(input int unsigned n);
        int m = 0;
        if (n == 0) return 1;
        for (int unsigned i = 0; i < 32; i++) if ((n >> i) != 0) m = int'(i);
        return 2 * m + 2;
    endfunction

    // Starts an operation from IDLE and returns the cycle in which done rose.
    // inj_cyc>0: pulse start with (inj_x, inj_n) during that cycle of the run.
    task automatic run_op(input logic [31:0] x, input logic [NB-1:0] n,
                          input int inj_cyc, input logic [31:0] inj_x, input logic [NB-1:0] inj_n,
                          output int lat, output logic busy_ok);
        repeat (2) @(negedge CLK);
        start = 1'b1; X = x; N = n;
        @(posedge CLK); #1;
        start   = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 1000) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (lat == inj_cyc) begin
                start = 1'b1; X = inj_x; N = inj_n;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
            lat++;
        end
        start = 1'b0;
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; start = 1'b0; X = '0; N = '0;
        #12;
        total++;
        if ({busy, done, result, overflow, underflow} !== 35'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h ovf=%b unf=%b, want all 0",
                     busy, done, result, overflow, underflow);
        end
        @(negedge CLK); RST = 1'b1;
    endtask

    task automatic test_directed();
        int lat; logic bok;
        // 2.0^10
        run_op(32'h4000_0000, 8'd10, 0, '0, '0, lat, bok);
        total++; if (result !== 32'h4480_0000) begin bad++; $display("FAIL pow_2_10 result: got %h want 44800000", result); end
        total++; if (lat !== 8) begin bad++; $display("FAIL pow_2_10 latency: got %0d want 8", lat); end
        total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL pow_2_10 flags: got %b%b want 00", overflow, underflow); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL pow_2_10 busy: got profile bad want high until done"); end
        @(posedge CLK); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse: got done=%b one cycle later want 0", done); end
        // 3.0^0
        run_op(32'h4040_0000, 8'd0, 0, '0, '0, lat, bok);
        total++; if (result !== 32'h3F80_0000) begin bad++; $display("FAIL pow_n0 result: got %h want 3f800000", result); end
        total++; if (lat !== 1) begin bad++; $display("FAIL pow_n0 latency: got %0d want 1", lat); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL pow_n0 busy: got busy high want never"); end
        // NaN^0
        run_op(32'h7FC0_0000, 8'd0, 0, '0, '0, lat, bok);
        total++; if (result !== 32'h3F80_0000 || {overflow, underflow} !== 2'b00) begin
            bad++; $display("FAIL pow_nan_0: got %h flags %b%b want 3f800000 00", result, overflow, underflow); end
        // -1.5^3
        run_op(32'hBFC0_0000, 8'd3, 0, '0, '0, lat, bok);
        total++; if (result !== 32'hC058_0000) begin bad++; $display("FAIL pow_neg_3 result: got %h want c0580000", result); end
        total++; if (lat !== 4) begin bad++; $display("FAIL pow_neg_3 latency: got %0d want 4", lat); end
        // 2^100 squared overflows
        run_op(32'h7180_0000, 8'd2, 0, '0, '0, lat, bok);
        total++; if ({overflow, underflow} !== 2'b10) begin bad++; $display("FAIL pow_ovf flags: got %b%b want 10", overflow, underflow); end
        // 2^-100 squared underflows
        run_op(32'h0D80_0000, 8'd2, 0, '0, '0, lat, bok);
        total++; if ({overflow, underflow} !== 2'b01) begin bad++; $display("FAIL pow_unf flags: got %b%b want 01", overflow, underflow); end
        total++; if (result[30:23] !== 8'd0) begin bad++; $display("FAIL pow_unf exponent: got %h want 00", result[30:23]); end
    endtask

    task automatic test_back_to_back();
        int lat; logic bok;
        run_op(32'h7180_0000, 8'd2, 0, '0, '0, lat, bok);
        // start pulsed mid-run with a different operand must not disturb the result
        run_op(32'h4000_0000, 8'd10, 3, 32'h4040_0000, 8'd1, lat, bok);
        total++; if (result !== 32'h4480_0000 || lat !== 8) begin
            bad++; $display("FAIL b2b_busy_start: got %h lat %0d want 44800000 lat 8", result, lat); end
        total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL b2b_flags_cleared: got %b%b want 00", overflow, underflow); end
        // start during the FIN cycle is dropped
        start = 1'b1; X = 32'h4040_0000; N = 8'd1;
        @(posedge CLK); #1; start = 1'b0;
        @(posedge CLK); #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL fin_start_ignored: got busy=%b done=%b want 0 0", busy, done); end
        total++; if (result !== 32'h4480_0000) begin bad++; $display("FAIL result_hold: got %h want 44800000", result); end
    endtask

    task automatic test_reset_mid();
        int lat; logic bok;
        repeat (2) @(negedge CLK);
        start = 1'b1; X = 32'h4000_0000; N = 8'd10;
        @(posedge CLK); #1; start = 1'b0;
        repeat (2) @(posedge CLK);
        #3;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
        RST = 1'b0;
        #1;
        total++; if ({busy, done, result, overflow, underflow} !== 35'd0) begin
            bad++; $display("FAIL async_reset: got busy=%b done=%b result=%h ovf=%b unf=%b want all 0",
                            busy, done, result, overflow, underflow); end
        @(negedge CLK); RST = 1'b1;
        run_op(32'h4000_0000, 8'd1, 0, '0, '0, lat, bok);
        total++; if (result !== 32'h4000_0000 || lat !== 2) begin
            bad++; $display("FAIL after_reset: got %h lat %0d want 40000000 lat 2", result, lat); end
    endtask

    task automatic test_random();
        int lat; logic bok;
        logic [31:0] x, want;
        int unsigned n;
        for (int i = 0; i < 60; i++) begin
            if (i % 2 == 0) begin
                // near 1.0: stays in range up to N=255
                x = {1'($urandom), 8'd127, 8'd0, 15'($urandom_range(0, 32767))};
                n = $urandom_range(0, 255);
            end else begin
                x = {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
                n = $urandom_range(0, 15);
            end
            want = model_pow(x, n);
            run_op(x, NB'(n), 0, '0, '0, lat, bok);
            total++; if (result !== want) begin bad++; $display("FAIL rand_result x=%h n=%0d: got %h want %h", x, n, result, want); end
            total++; if (lat !== model_lat(n)) begin bad++; $display("FAIL rand_latency n=%0d: got %0d want %0d", n, lat, model_lat(n)); end
            total++; if ({overflow, underflow, bok} !== 3'b001) begin
                bad++; $display("FAIL rand_flags_busy n=%0d: got ovf=%b unf=%b busy_ok=%b want 0 0 1", n, overflow, underflow, bok); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
